dither_scan_ctl: RTL
====================

# dither_scan_ctl

Parametrised successor to the single-channel dithering loop controller. Sequences the Floyd-Steinberg pixel datapath over an IMAGEX×IMAGEY image with CHANNELS colour planes per pixel, producing one-hot phase strobes and explicit x/y/channel/address coordinates. Adds a start/ack handshake with the MCU bridge, mid-frame abort, and an optional serpentine scan. Sits between the SPI/MCU front end and the pixel accelerator / SRAM ports.

## Interface
Parameters:
- IMAGEX, 256, image width in pixels (≥2)
- IMAGEY, 256, image height in pixels (≥1)
- CHANNELS, 3, colour planes per pixel (≥1)
- DIFF_PHASES, 5, diffusion/compute cycles per pixel-channel (≥1)
- SETTLE_CYCLES, 4, idle cycles after start before the first pixel (≥1)
- ADDR_W, $clog2(IMAGEX*IMAGEY), pixel address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; frame request from MCU bridge
- abort  in  1  level; cancel frame in progress
- ack  in  1  level; MCU has consumed result
- scan_mode  in  1  0 raster, 1 serpentine (sampled at frame start)
- state  out  state_t  current FSM state
- busy  out  1  high in SETTLE..DIFFUSE
- done  out  1  high in DONE
- load_old  out  1  strobe: fetch original pixel value
- quant  out  1  strobe: compare/quantise and store new value
- diff_phase  out  DIFF_PHASES  one-hot diffusion strobe
- px_x  out  $clog2(IMAGEX)  current column
- px_y  out  $clog2(IMAGEY)  current row
- px_ch  out  $clog2(CHANNELS) (min 1)  current channel
- px_addr  out  ADDR_W  px_y*IMAGEX + px_x, registered
- dir_rev  out  1  current row traversed right-to-left
- last_pixel  out  1  px_x/px_y/px_ch address the final pixel-channel of the frame

## Operation
- States: IDLE, SETTLE, LOAD, QUANT, DIFFUSE, DONE.
- IDLE: counters held at 0. start=1 → SETTLE; latch scan_mode.
- SETTLE: settle counter cleared on entry; after SETTLE_CYCLES cycles → LOAD.
- LOAD: load_old=1, one cycle → QUANT.
- QUANT: quant=1, one cycle → DIFFUSE.
- DIFFUSE: phase counter 0..DIFF_PHASES-1, diff_phase = 1<<phase. On the final phase: if last_pixel → DONE, else advance coordinates → LOAD.
- Advance order: px_ch increments first; on wrap to 0, px_x steps (+1 raster or forward row; −1 reversed row); at row end, px_y+1 and, in serpentine, dir_rev toggles with px_x staying at the edge column (IMAGEX−1 or 0).
- Raster: dir_rev always 0, every row starts at px_x=0.
- DONE: done=1, counters frozen on final pixel. ack=1 → IDLE (counters cleared). start ignored in DONE.
- abort=1 in any state other than IDLE → IDLE next cycle, counters and phase cleared, no strobes in that cycle. abort has priority over ack and over the DIFFUSE advance.
- start while busy: ignored. scan_mode changes mid-frame: ignored.
- Strobes (load_old, quant, diff_phase) are mutually exclusive and zero outside their states.

## Timing
- Reset values: state=IDLE; busy, done, load_old, quant, diff_phase, px_x, px_y, px_ch, px_addr, dir_rev = 0; last_pixel=0.
- Strobes are decoded from state; they are asserted in the same cycle as the state.
- Per pixel-channel: 2+DIFF_PHASES cycles (7 with defaults). Frame latency from start sampled to done = 1 + SETTLE_CYCLES + IMAGEX·IMAGEY·CHANNELS·(2+DIFF_PHASES) cycles.
- Coordinates update on the clock edge that leaves the final DIFFUSE phase; they are stable through LOAD, QUANT, DIFFUSE.
- px_addr is registered alongside the coordinates, with no extra latency.
- last_pixel is combinational from the coordinates.

## Configuration
- DITHER_SERPENTINE_EN defined: scan_mode honoured; serpentine reversal and dir_rev implemented.
- Undefined: scan_mode ignored, raster only, dir_rev tied to 0, and the reverse-stepping logic is absent.

## Structure
- Package dither_pkg: state_t enum (IDLE, SETTLE, LOAD, QUANT, DIFFUSE, DONE) and a scan_mode_t constant pair (SCAN_RASTER, SCAN_SERP).
- Sub-module pixel_scan_counter: owns px_x/px_y/px_ch/dir_rev/px_addr, with inputs clr, adv and serp, and output last.
- The FSM, settle counter and phase counter stay in dither_scan_ctl.

## Test plan
- IMAGEX=4, IMAGEY=2, CHANNELS=1, raster, start pulse → px_addr sequence 0..7, done exactly 1+4+8·7=61 cycles after start is sampled; ack → IDLE.
- Same image, serpentine (macro defined) → px_x order 0,1,2,3,3,2,1,0; dir_rev=1 on row 1; px_addr 0,1,2,3,7,6,5,4.
- CHANNELS=3 → each pixel visited with px_ch 0,1,2 before px_x advances; load_old count 24 per frame.
- abort asserted during DIFFUSE phase 2 of pixel 5 → IDLE next cycle, all strobes 0, px_addr=0; a fresh start restarts at pixel 0.
- start held high through the frame and in DONE → no restart until ack; ack and abort together in DONE → IDLE.
- rst asserted low mid-frame (async, between edges) → outputs at reset values immediately; macro undefined with scan_mode=1 → raster order, dir_rev=0.

Source files
------------

// File: rtl/dither_pkg.sv
// Shared types for the dithering scan controller: FSM state encoding,
// scan-order selector and a width helper for parameter-sized ports.
package dither_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    LOAD    = 3'd2,
    QUANT   = 3'd3,
    DIFFUSE = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic {
    SCAN_RASTER = 1'b0,
    SCAN_SERP   = 1'b1
  } scan_mode_t;

  // Counter width for a range of v values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Pixel/channel coordinate walker for the dithering scan.
// Owns px_x/px_y/px_ch/px_addr and the row direction. The address is tracked
// incrementally (+1, -1 or +IMAGEX) so no multiplier is needed.
// Build option: DITHER_SERPENTINE_EN enables reversed rows; without it the
// walker is raster-only and dir_rev is tied low.
module pixel_scan_counter
  import dither_pkg::*;
#(
  parameter int IMAGEX   = 256,
  parameter int IMAGEY   = 256,
  parameter int CHANNELS = 3,
  parameter int ADDR_W   = $clog2(IMAGEX * IMAGEY)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              adv,
  input  logic                              serp,
  output logic [$clog2(IMAGEX)-1:0]         px_x,
  output logic [clog2_min1(IMAGEY)-1:0]     px_y,
  output logic [clog2_min1(CHANNELS)-1:0]   px_ch,
  output logic [ADDR_W-1:0]                 px_addr,
  output logic                              dir_rev,
  output logic                              last
);

  localparam int X_W = $clog2(IMAGEX);
  localparam int Y_W = clog2_min1(IMAGEY);
  localparam int C_W = clog2_min1(CHANNELS);

  localparam logic [X_W-1:0]    X_LAST   = X_W'(IMAGEX - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(IMAGEY - 1);
  localparam logic [C_W-1:0]    C_LAST   = C_W'(CHANNELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ROW = ADDR_W'(IMAGEX);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [C_W-1:0]    ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

`ifdef DITHER_SERPENTINE_EN
  logic dir_q, dir_d;
`else
  logic unused_serp;
  assign unused_serp = serp;
`endif

  // Next coordinates: channel first, then column, then row.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    ch_d   = ch_q;
    addr_d = addr_q;
`ifdef DITHER_SERPENTINE_EN
    dir_d  = dir_q;
`endif
    if (clr) begin
      x_d    = '0;
      y_d    = '0;
      ch_d   = '0;
      addr_d = '0;
`ifdef DITHER_SERPENTINE_EN
      dir_d  = 1'b0;
`endif
    end else if (adv) begin
      if (ch_q != C_LAST) begin
        ch_d = ch_q + 1'b1;
      end else begin
        ch_d = '0;
`ifdef DITHER_SERPENTINE_EN
        if (dir_q) begin
          if (x_q != '0) begin
            x_d    = x_q - 1'b1;
            addr_d = addr_q - 1'b1;
          end else begin
            // left edge of a reversed row: drop a row, keep column 0
            y_d    = y_q + 1'b1;
            dir_d  = 1'b0;
            addr_d = addr_q + ADDR_ROW;
          end
        end else if (x_q != X_LAST) begin
          x_d    = x_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end else if (serp) begin
          // right edge in serpentine: drop a row, keep column IMAGEX-1
          y_d    = y_q + 1'b1;
          dir_d  = 1'b1;
          addr_d = addr_q + ADDR_ROW;
        end else begin
          x_d    = '0;
          y_d    = y_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
`else
        if (x_q != X_LAST) begin
          x_d = x_q + 1'b1;
        end else begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end
        addr_d = addr_q + 1'b1;
`endif
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      ch_q   <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      ch_q   <= ch_d;
      addr_q <= addr_d;
    end
  end

`ifdef DITHER_SERPENTINE_EN
  // Row direction register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dir_q <= 1'b0;
    else      dir_q <= dir_d;
  end

  assign dir_rev = dir_q;
  assign last    = (ch_q == C_LAST) && (y_q == Y_LAST) &&
                   (x_q == (dir_q ? '0 : X_LAST));
`else
  assign dir_rev = 1'b0;
  assign last    = (ch_q == C_LAST) && (y_q == Y_LAST) && (x_q == X_LAST);
`endif

  assign px_x    = x_q;
  assign px_y    = y_q;
  assign px_ch   = ch_q;
  assign px_addr = addr_q;

endmodule

// File: rtl/dither_scan_ctl.sv
// Frame sequencer for the Floyd-Steinberg pixel datapath.
// Handles start/ack with the MCU bridge, abort, settle delay and per
// pixel-channel LOAD/QUANT/DIFFUSE phases. Strobes are registered from the
// next state so they line up with the state output.
// Build option: DITHER_SERPENTINE_EN honours scan_mode (serpentine scan).
//
// state   | meaning
// IDLE    | waiting for start, coordinates held at 0
// SETTLE  | SETTLE_CYCLES wait before the first pixel
// LOAD    | load_old strobe, fetch original pixel-channel value
// QUANT   | quant strobe, quantise and store
// DIFFUSE | one-hot diff_phase strobes, advance coordinates on last phase
// DONE    | frame complete, coordinates frozen until ack
module dither_scan_ctl
  import dither_pkg::*;
#(
  parameter int IMAGEX        = 256,
  parameter int IMAGEY        = 256,
  parameter int CHANNELS      = 3,
  parameter int DIFF_PHASES   = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int ADDR_W        = $clog2(IMAGEX * IMAGEY)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              ack,
  input  logic                              scan_mode,
  output state_t                            state,
  output logic                              busy,
  output logic                              done,
  output logic                              load_old,
  output logic                              quant,
  output logic [DIFF_PHASES-1:0]            diff_phase,
  output logic [$clog2(IMAGEX)-1:0]         px_x,
  output logic [clog2_min1(IMAGEY)-1:0]     px_y,
  output logic [clog2_min1(CHANNELS)-1:0]   px_ch,
  output logic [ADDR_W-1:0]                 px_addr,
  output logic                              dir_rev,
  output logic                              last_pixel
);

  localparam int S_W = clog2_min1(SETTLE_CYCLES);
  localparam int P_W = clog2_min1(DIFF_PHASES);

  localparam logic [S_W-1:0] S_LOAD = S_W'(SETTLE_CYCLES - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(DIFF_PHASES - 1);

  state_t                 state_q, state_d;
  logic [S_W-1:0]         settle_q, settle_d;
  logic [P_W-1:0]         phase_q, phase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   load_q, load_d;
  logic                   quant_q, quant_d;
  logic [DIFF_PHASES-1:0] diff_q, diff_d;
  logic                   clr, adv, serp, last;

`ifdef DITHER_SERPENTINE_EN
  scan_mode_t scan_q, scan_d;
  assign serp = (scan_q == SCAN_SERP);
`else
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;
  assign serp = 1'b0;
`endif

  // Next-state, counter and strobe decode; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    phase_d  = phase_q;
    clr      = 1'b0;
    adv      = 1'b0;
`ifdef DITHER_SERPENTINE_EN
    scan_d   = scan_q;
`endif
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      settle_d = '0;
      phase_d  = '0;
      clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clr     = 1'b1;
          phase_d = '0;
          if (start) begin
            state_d  = SETTLE;
            settle_d = S_LOAD;
`ifdef DITHER_SERPENTINE_EN
            scan_d   = scan_mode_t'(scan_mode);
`endif
          end
        end
        SETTLE: begin
          if (settle_q == '0) state_d = LOAD;
          else                settle_d = settle_q - 1'b1;
        end
        LOAD:  state_d = QUANT;
        QUANT: begin
          state_d = DIFFUSE;
          phase_d = '0;
        end
        DIFFUSE: begin
          if (phase_q == P_LAST) begin
            phase_d = '0;
            if (last) begin
              state_d = DONE;
            end else begin
              state_d = LOAD;
              adv     = 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            state_d = IDLE;
            clr     = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      endcase
    end

    busy_d  = (state_d == SETTLE) || (state_d == LOAD) ||
              (state_d == QUANT)  || (state_d == DIFFUSE);
    done_d  = (state_d == DONE);
    load_d  = (state_d == LOAD);
    quant_d = (state_d == QUANT);
    diff_d  = '0;
    if (state_d == DIFFUSE) diff_d[phase_d] = 1'b1;
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      quant_q  <= 1'b0;
      diff_q   <= '0;
`ifdef DITHER_SERPENTINE_EN
      scan_q   <= SCAN_RASTER;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      load_q   <= load_d;
      quant_q  <= quant_d;
      diff_q   <= diff_d;
`ifdef DITHER_SERPENTINE_EN
      scan_q   <= scan_d;
`endif
    end
  end

  pixel_scan_counter #(
    .IMAGEX   (IMAGEX),
    .IMAGEY   (IMAGEY),
    .CHANNELS (CHANNELS),
    .ADDR_W   (ADDR_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .adv     (adv),
    .serp    (serp),
    .px_x    (px_x),
    .px_y    (px_y),
    .px_ch   (px_ch),
    .px_addr (px_addr),
    .dir_rev (dir_rev),
    .last    (last)
  );

  assign state      = state_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_old   = load_q;
  assign quant      = quant_q;
  assign diff_phase = diff_q;
  assign last_pixel = last;

endmodule
